// File: rtl/tff_bank_sequencer_if.sv
// tff_bank_sequencer_if: command handshake and bank status bundle for the toggle-flop sequencer
interface tff_bank_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_len;
    logic             hold;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             wrap;
    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_len, hold,
        input  cmd_ready, t_vec, q, busy, done, wrap
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_len, hold,
        output cmd_ready, t_vec, q, busy, done, wrap
    );
endinterface

// File: rtl/tff_bank_sequencer.sv
// tff_bank_sequencer: sequences a T-flop bank via a toggle mask for count up/down, load and clear
module tff_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input logic                clk,
    input logic                rst,
    tff_bank_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] q_q;
    logic [CNT_W-1:0] rem_q;
    logic             done_q;
    logic             wrap_q;
    logic             step;
    logic             wrap_d;
    logic [WIDTH-1:0] t_d;
    always_comb begin
        step   = state_q == RUN && !bus.hold;
        t_d    = !step          ? '0 :
                 op_q == 2'b00 ? (q_q + WIDTH'(1)) ^ q_q :
                 op_q == 2'b01 ? (q_q - WIDTH'(1)) ^ q_q :
                 op_q == 2'b10 ? q_q ^ data_q : q_q;
        wrap_d = step && ((op_q == 2'b00 && &q_q) || (op_q == 2'b01 && ~|q_q));
    end
    // q only ever changes through t_vec, so external T-flops driven by t_vec stay in lockstep
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            data_q  <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            q_q    <= q_q ^ t_d;
            wrap_q <= wrap_d;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.cmd_valid) begin
                    op_q   <= bus.cmd_op;
                    data_q <= bus.cmd_data;
                    if (!bus.cmd_op[1] && bus.cmd_len == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= RUN;
                        rem_q   <= bus.cmd_op[1] ? CNT_W'(1) : bus.cmd_len;
                    end
                end
                RUN: if (step) begin
                    rem_q <= rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.cmd_ready = state_q == IDLE;
    assign bus.busy      = state_q == RUN;
    assign bus.t_vec     = t_d;
    assign bus.q         = q_q;
    assign bus.done      = done_q;
    assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_tff_bank_sequencer.sv
// tb_tff_bank_sequencer: directed command table plus reset-abort sequence for the T-flop sequencer
module tb_tff_bank_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tff_bank_sequencer_if #(.WIDTH(4), .CNT_W(8)) bus ();
    tff_bank_sequencer #(.WIDTH(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  data;
        logic [7:0]  len;
        int          hold_at;
        int          hold_n;
        bit          noise;
        logic [31:0] tv;
        logic [3:0]  q;
        int          busy;
        int          wraps;
    } vec_t;

    vec_t tbl[10];
    int pass_n = 0;
    int total_n = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_n++;
        if (got === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] data, input logic [7:0] len);
        int w = 0;
        @(negedge clk);
        while (!bus.cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_len   = len;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        int k = 0;
        int wraps = 0;
        int dones = 0;
        logic [31:0] got_tv = '0;
        send(tbl[idx].op, tbl[idx].data, tbl[idx].len);
        for (int c = 0; c < 40 && dones == 0; c++) begin
            @(negedge clk);
            bus.hold = bus.busy && k >= tbl[idx].hold_at && k < tbl[idx].hold_at + tbl[idx].hold_n;
            if (tbl[idx].noise) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = 2'b10;
                bus.cmd_data  = 4'b1010;
            end
            #1;
            if (bus.busy) begin
                if (k < 8) got_tv[k*4 +: 4] = bus.t_vec;
                k++;
            end
            if (bus.wrap) wraps++;
            if (bus.done) begin
                dones++;
                bus.cmd_valid = 1'b0;
                bus.hold      = 1'b0;
            end
        end
        bus.cmd_valid = 1'b0;
        bus.hold      = 1'b0;
        check($sformatf("v%0d_tvec", idx), got_tv, tbl[idx].tv);
        check($sformatf("v%0d_q", idx), {28'd0, bus.q}, {28'd0, tbl[idx].q});
        check($sformatf("v%0d_busy", idx), k, tbl[idx].busy);
        check($sformatf("v%0d_wrap", idx), wraps, tbl[idx].wraps);
        check($sformatf("v%0d_done", idx), dones, 1);
        @(negedge clk);
        #1;
        check($sformatf("v%0d_ready_after", idx), {30'd0, bus.cmd_ready, bus.done}, 32'd2);
        check($sformatf("v%0d_q_after", idx), {28'd0, bus.q}, {28'd0, tbl[idx].q});
    endtask

    initial begin
        int dones;
        tbl[0] = '{2'b00, 4'h0, 8'd3, 99, 0, 1'b1, 32'h00000131, 4'h3, 3, 0};
        tbl[1] = '{2'b11, 4'h0, 8'd0, 99, 0, 1'b0, 32'h00000003, 4'h0, 1, 0};
        tbl[2] = '{2'b10, 4'hE, 8'd0, 99, 0, 1'b0, 32'h0000000E, 4'hE, 1, 0};
        tbl[3] = '{2'b00, 4'h0, 8'd2, 99, 0, 1'b0, 32'h000000F1, 4'h0, 2, 1};
        tbl[4] = '{2'b01, 4'h0, 8'd1, 99, 0, 1'b0, 32'h0000000F, 4'hF, 1, 1};
        tbl[5] = '{2'b11, 4'h0, 8'd0, 99, 0, 1'b0, 32'h0000000F, 4'h0, 1, 0};
        tbl[6] = '{2'b00, 4'h0, 8'd4, 1, 2, 1'b0, 32'h00713001, 4'h4, 6, 0};
        tbl[7] = '{2'b10, 4'h4, 8'd0, 99, 0, 1'b0, 32'h00000000, 4'h4, 1, 0};
        tbl[8] = '{2'b01, 4'h0, 8'd3, 99, 0, 1'b0, 32'h00000317, 4'h1, 3, 0};
        tbl[9] = '{2'b00, 4'h0, 8'd0, 99, 0, 1'b1, 32'h00000000, 4'h1, 0, 0};
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 4'h0;
        bus.cmd_len   = 8'd0;
        bus.hold      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", {28'd0, bus.q}, 32'd0);
        check("rst_flags", {28'd0, bus.cmd_ready, bus.busy, bus.done, bus.wrap}, 32'h8);
        check("rst_tvec", {28'd0, bus.t_vec}, 32'd0);
        rst = 1'b0;
        // reach q = 5, then abort a long count with reset mid-run
        send(2'b10, 4'h5, 8'd0);
        repeat (3) @(negedge clk);
        check("load5_q", {28'd0, bus.q}, 32'd5);
        send(2'b00, 4'h0, 8'd10);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_q", {28'd0, bus.q}, 32'd0);
        check("abort_flags", {28'd0, bus.cmd_ready, bus.busy, bus.done, bus.wrap}, 32'h8);
        dones = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("abort_no_done", dones, 0);
        for (int i = 0; i < 10; i++) run_vec(i);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
